// File: rtl/mem_write_checker.sv
// In-order store checker for the MIPS external-memory bus: compares each memwrite
// against a loaded (adr, data) table. MEM_WRITE_CHECKER_EXTRA_EN makes stores after PASS fail.
module mem_write_checker #(
  parameter int WIDTH   = 8,
  parameter int DEPTH   = 4,
  parameter int IDXBITS = 2,
  parameter int CBITS   = 16,
  parameter int TIMEOUT = 1000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load_en,
  input  logic [WIDTH-1:0]   load_adr,
  input  logic [WIDTH-1:0]   load_data,
  input  logic               start,
  input  logic               memwrite,
  input  logic [WIDTH-1:0]   adr,
  input  logic [WIDTH-1:0]   writedata,
  output logic               done,
  output logic               pass,
  output logic               fail,
  output logic               timeout,
  output logic [IDXBITS-1:0] err_idx,
  output logic [WIDTH-1:0]   got_adr,
  output logic [WIDTH-1:0]   got_data,
  output logic [CBITS-1:0]   cycles,
  output logic [IDXBITS:0]   nloaded
);
  typedef struct packed {
    logic [WIDTH-1:0] adr;
    logic [WIDTH-1:0] data;
  } entry_t;

  typedef enum logic [1:0] {S_LOAD, S_RUN, S_PASS, S_FAIL} state_t;

  localparam logic [CBITS-1:0] CMAX = '1;
  localparam logic [CBITS-1:0] TO   = CBITS'(TIMEOUT);
  localparam logic [IDXBITS:0] FULL = (IDXBITS+1)'(DEPTH);

  state_t             state;
  entry_t             tbl [DEPTH];
  logic [IDXBITS-1:0] ptr;
  entry_t             obs;
  logic               hit, last;
  logic [CBITS-1:0]   cyc_nxt;

  // Case equality so X/Z on the bus never counts as a match.
  always_comb begin
    obs     = '{adr: adr, data: writedata};
    hit     = (obs === tbl[ptr]);
    last    = ({1'b0, ptr} == nloaded - 1'b1);
    cyc_nxt = (cycles == CMAX) ? cycles : cycles + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_LOAD;
      ptr      <= '0;
      nloaded  <= '0;
      done     <= 1'b0;
      pass     <= 1'b0;
      fail     <= 1'b0;
      timeout  <= 1'b0;
      err_idx  <= '0;
      got_adr  <= '0;
      got_data <= '0;
      cycles   <= '0;
    end else begin
      case (state)
        S_LOAD: begin
          if (load_en && nloaded != FULL) begin
            tbl[nloaded[IDXBITS-1:0]] <= '{adr: load_adr, data: load_data};
            nloaded <= nloaded + 1'b1;
          end
          if (start) begin
            if (nloaded == '0 && !load_en) begin
              state <= S_PASS;
              done  <= 1'b1;
              pass  <= 1'b1;
            end else begin
              state <= S_RUN;
            end
          end
        end
        S_RUN: begin
          cycles <= cyc_nxt;
          if (memwrite && !hit) begin
            state    <= S_FAIL;
            done     <= 1'b1;
            fail     <= 1'b1;
            err_idx  <= ptr;
            got_adr  <= adr;
            got_data <= writedata;
          end else if (memwrite && last) begin
            state <= S_PASS;
            done  <= 1'b1;
            pass  <= 1'b1;
          end else begin
            // A non-final match still advances before a coincident timeout is taken.
            if (memwrite) ptr <= ptr + 1'b1;
            if (cyc_nxt == TO) begin
              state   <= S_FAIL;
              done    <= 1'b1;
              fail    <= 1'b1;
              timeout <= 1'b1;
              err_idx <= memwrite ? ptr + 1'b1 : ptr;
            end
          end
        end
        S_PASS: begin
`ifdef MEM_WRITE_CHECKER_EXTRA_EN
          if (memwrite) begin
            state    <= S_FAIL;
            pass     <= 1'b0;
            fail     <= 1'b1;
            err_idx  <= nloaded[IDXBITS-1:0];
            got_adr  <= adr;
            got_data <= writedata;
          end
`endif
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_write_checker.sv
// Directed bench for mem_write_checker; honours MEM_WRITE_CHECKER_EXTRA_EN like the RTL.
module tb_mem_write_checker;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       load_en = 1'b0, start = 1'b0, memwrite = 1'b0;
  logic [7:0] load_adr = '0, load_data = '0, adr = '0, writedata = '0;
  logic       done, pass, fail, timeout;
  logic [1:0] err_idx;
  logic [7:0] got_adr, got_data;
  logic [15:0] cycles;
  logic [2:0] nloaded;

  int errs = 0, checks = 0;

  mem_write_checker #(.WIDTH(8), .DEPTH(4), .IDXBITS(2), .CBITS(16), .TIMEOUT(1000)) dut (
    .clk(clk), .reset(reset), .load_en(load_en), .load_adr(load_adr), .load_data(load_data),
    .start(start), .memwrite(memwrite), .adr(adr), .writedata(writedata),
    .done(done), .pass(pass), .fail(fail), .timeout(timeout), .err_idx(err_idx),
    .got_adr(got_adr), .got_data(got_data), .cycles(cycles), .nloaded(nloaded)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic load(input logic [7:0] a, input logic [7:0] d);
    load_en = 1'b1; load_adr = a; load_data = d;
    step();
    load_en = 1'b0;
  endtask

  task automatic go();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic store(input logic [7:0] a, input logic [7:0] d);
    memwrite = 1'b1; adr = a; writedata = d;
    step();
    memwrite = 1'b0;
  endtask

  initial begin
    step(); step();
    reset = 1'b0;
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_fail", fail, 0);
    chk("rst_cycles", cycles, 0);
    chk("rst_nloaded", nloaded, 0);

    // 1: single matching store in RUN cycle 10
    do_reset();
    load(8'h2C, 8'h15);
    go();
    repeat (9) step();
    chk("t1_pre_done", done, 0);
    store(8'h2C, 8'h15);
    chk("t1_done", done, 1);
    chk("t1_pass", pass, 1);
    chk("t1_fail", fail, 0);
    chk("t1_cycles", cycles, 10);

    // 2: second store has wrong data
    do_reset();
    load(8'h1C, 8'h0A);
    load(8'h2C, 8'h15);
    go();
    store(8'h1C, 8'h0A);
    chk("t2_mid_done", done, 0);
    store(8'h2C, 8'h16);
    chk("t2_fail", fail, 1);
    chk("t2_pass", pass, 0);
    chk("t2_err_idx", err_idx, 1);
    chk("t2_got_adr", got_adr, 8'h2C);
    chk("t2_got_data", got_data, 8'h16);
    chk("t2_timeout", timeout, 0);

    // 3: timeout with no stores
    do_reset();
    load(8'h4C, 8'h07);
    go();
    for (int i = 0; i < 1100 && !done; i++) step();
    chk("t3_fail", fail, 1);
    chk("t3_timeout", timeout, 1);
    chk("t3_err_idx", err_idx, 0);
    chk("t3_cycles", cycles, 1000);
    chk("t3_got_adr", got_adr, 0);
    repeat (5) step();
    chk("t3_cycles_frozen", cycles, 1000);

    // 4: overfill the table, then empty-table start
    do_reset();
    for (int i = 0; i < 5; i++) load(8'(i), 8'(i + 1));
    chk("t4_nloaded", nloaded, 4);
    do_reset();
    go();
    chk("t4_empty_pass", pass, 1);
    chk("t4_empty_done", done, 1);
    chk("t4_empty_cycles", cycles, 0);

    // 5: reset mid-RUN, memwrite ignored in LOAD
    do_reset();
    load(8'h2C, 8'h15);
    load(8'h30, 8'h01);
    go();
    store(8'h2C, 8'h15);
    do_reset();
    chk("t5_done", done, 0);
    chk("t5_nloaded", nloaded, 0);
    chk("t5_cycles", cycles, 0);
    store(8'h2C, 8'h15);
    chk("t5_load_store_done", done, 0);
    chk("t5_load_store_cycles", cycles, 0);
    load(8'h11, 8'h22);
    chk("t5_nloaded_after", nloaded, 1);
    go();
    store(8'h11, 8'h22);
    chk("t5_pass", pass, 1);

    // X on the data bus is a mismatch
    do_reset();
    load(8'h2C, 8'h15);
    go();
    store(8'h2C, 8'hxx);
    chk("tx_fail", fail, 1);
    chk("tx_got_adr", got_adr, 8'h2C);

    // 6: store after PASS
    do_reset();
    load(8'h2C, 8'h15);
    go();
    store(8'h2C, 8'h15);
    chk("t6_pass_first", pass, 1);
    store(8'h30, 8'h01);
`ifdef MEM_WRITE_CHECKER_EXTRA_EN
    chk("t6_pass", pass, 0);
    chk("t6_fail", fail, 1);
    chk("t6_err_idx", err_idx, 1);
    chk("t6_got_adr", got_adr, 8'h30);
    chk("t6_got_data", got_data, 8'h01);
`else
    chk("t6_pass", pass, 1);
    chk("t6_fail", fail, 0);
    chk("t6_got_adr", got_adr, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
